// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: T-state / M-cycle timing generator for the CPU
// control unit, with HALT/STOP low-power states and IR latch strobe.
//
// Ports:
//   i_Clk, i_Reset      clock, synchronous active-high reset
//   i_Fetch             instruction ends at this M-cycle (OR of decoders)
//   i_Halt, i_Stop      HALT/STOP opcode, qualified by i_Fetch
//   i_Wait              bus stall, freezes all sequencing
//   i_Int_Pending       HALT wake source
//   i_Wake              STOP wake source
//   o_Cycle_Step        one-hot T-state (bit0 = T1)
//   o_Cycle_Count       one-hot M-cycle (bit0 = M1), zero in HALT/STOP
//   o_IR_Latch          one-clock IR load strobe
//   o_Halted, o_Stopped state flags
//   o_Cycle_Error       sticky M-cycle overflow flag
//   o_MCycle_Total      RUN boundary count (CPU_CYCLE_SEQ_PERF_COUNTER_EN)
//
// Build option: define CPU_CYCLE_SEQ_PERF_COUNTER_EN to add o_MCycle_Total.

module cpu_cycle_sequencer #(
  parameter int T_STATES    = 4,
  parameter int MAX_MCYCLES = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Fetch,
  input  logic                   i_Halt,
  input  logic                   i_Stop,
  input  logic                   i_Wait,
  input  logic                   i_Int_Pending,
  input  logic                   i_Wake,
`ifdef CPU_CYCLE_SEQ_PERF_COUNTER_EN
  output logic [31:0]            o_MCycle_Total,
`endif
  output logic [T_STATES-1:0]    o_Cycle_Step,
  output logic [MAX_MCYCLES-1:0] o_Cycle_Count,
  output logic                   o_IR_Latch,
  output logic                   o_Halted,
  output logic                   o_Stopped,
  output logic                   o_Cycle_Error
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [T_STATES-1:0] STEP_T1 =
    T_STATES'(1);
  localparam logic [MAX_MCYCLES-1:0] CNT_M1 =
    MAX_MCYCLES'(1);
  localparam logic [MAX_MCYCLES-1:0] CNT_ZERO =
    '0;

  logic [T_STATES-1:0]    r_step;
  logic [MAX_MCYCLES-1:0] r_count;
  logic [1:0]             r_state;
  logic                   r_err;
  // Set on STOP exit: the opcode after STOP must be
  // fetched at the first boundary without decoder help.
  logic                   r_pend;

  logic w_bnd;
  logic w_fetch;
  logic w_go_stop;
  logic w_go_halt;
  logic w_run_ld;
  logic w_halt_ld;
  logic [T_STATES-1:0] w_rot;

  assign w_bnd     = r_step[T_STATES-1] & ~i_Wait;
  assign w_fetch   = i_Fetch | r_pend;
  assign w_go_stop = i_Fetch & i_Stop;
  // A pending interrupt cancels HALT entry outright.
  assign w_go_halt = i_Fetch & i_Halt & ~i_Stop
                   & ~i_Int_Pending;
  assign w_run_ld  = (r_state == S_RUN) & w_fetch
                   & ~w_go_stop & ~w_go_halt;
  assign w_halt_ld = (r_state == S_HALT) & i_Int_Pending;
  assign w_rot     = {r_step[T_STATES-2:0],
                      r_step[T_STATES-1]};

  assign o_IR_Latch = ~i_Reset & w_bnd
                    & (w_run_ld | w_halt_ld);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_step  <= STEP_T1;
      r_count <= CNT_M1;
      r_state <= S_RUN;
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
    end else if (!i_Wait) begin
      case (r_state)
        S_RUN: begin
          r_step <= w_rot;
          if (w_bnd) begin
            if (w_go_stop) begin
              r_state <= S_STOP;
              r_count <= CNT_ZERO;
              r_step  <= STEP_T1;
              r_pend  <= 1'b0;
            end else if (w_go_halt) begin
              r_state <= S_HALT;
              r_count <= CNT_ZERO;
              r_pend  <= 1'b0;
            end else if (w_fetch) begin
              r_count <= CNT_M1;
              r_pend  <= 1'b0;
            end else if (r_count[MAX_MCYCLES-1]) begin
              r_count <= CNT_M1;
              r_err   <= 1'b1;
            end else begin
              r_count <= r_count << 1;
            end
          end
        end
        S_HALT: begin
          r_step <= w_rot;
          if (w_bnd && i_Int_Pending) begin
            r_state <= S_RUN;
            r_count <= CNT_M1;
          end
        end
        S_STOP: begin
          r_step <= STEP_T1;
          if (i_Wake) begin
            r_state <= S_RUN;
            r_count <= CNT_M1;
            r_pend  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_step  <= STEP_T1;
          r_count <= CNT_M1;
        end
      endcase
    end
  end

`ifdef CPU_CYCLE_SEQ_PERF_COUNTER_EN
  logic [31:0] r_total;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_total <= 32'd0;
    end else if (w_bnd && r_state == S_RUN) begin
      r_total <= r_total + 32'd1;
    end
  end

  assign o_MCycle_Total = r_total;
`endif

  assign o_Cycle_Step  = r_step;
  assign o_Cycle_Count = r_count;
  assign o_Halted      = (r_state == S_HALT);
  assign o_Stopped     = (r_state == S_STOP);
  assign o_Cycle_Error = r_err;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: directed-vector bench for
// cpu_cycle_sequencer with per-clock invariant checks.

module tb_cpu_cycle_sequencer;

  logic       clk;
  logic       rst;
  logic       fetch, halt, stop, wt, intp, wake;
  logic [3:0] step;
  logic [7:0] cnt;
  logic       irl, hlt, stp, err;
`ifdef CPU_CYCLE_SEQ_PERF_COUNTER_EN
  logic [31:0] total;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  cpu_cycle_sequencer #(
    .T_STATES(4),
    .MAX_MCYCLES(8)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Fetch(fetch),
    .i_Halt(halt),
    .i_Stop(stop),
    .i_Wait(wt),
    .i_Int_Pending(intp),
    .i_Wake(wake),
`ifdef CPU_CYCLE_SEQ_PERF_COUNTER_EN
    .o_MCycle_Total(total),
`endif
    .o_Cycle_Step(step),
    .o_Cycle_Count(cnt),
    .o_IR_Latch(irl),
    .o_Halted(hlt),
    .o_Stopped(stp),
    .o_Cycle_Error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic chk_state(input string tag,
                           input logic [3:0] s,
                           input logic [7:0] c,
                           input logic h,
                           input logic p);
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".hlt"}, 32'(hlt), 32'(h));
    chk({tag, ".stp"}, 32'(stp), 32'(p));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("inv.step1hot", 32'($onehot(step)), 32'd1);
      if (hlt || stp)
        chk("inv.cnt0", 32'(cnt), 32'd0);
      else
        chk("inv.cnt1hot", 32'($onehot(cnt)), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; fetch = 0; halt = 0; stop = 0;
    wt = 0; intp = 0; wake = 0;
    clks(2);
    chk_state("rst", 4'b0001, 8'h01, 0, 0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.irl", 32'(irl), 32'd0);
    rst = 0;
    chk_en = 1;

    // free-running: 8 clocks without fetch
    for (int i = 1; i <= 8; i++) begin
      clk1();
      chk("run.step", 32'(step), 32'(1 << (i % 4)));
      chk("run.cnt", 32'(cnt), 32'(1 << (i / 4)));
    end

    // fetch at T2 is ignored, at T4 of M3 latches
    clk1();
    fetch = 1; #1;
    chk("t2.irl", 32'(irl), 32'd0);
    fetch = 0;
    clks(2);
    chk_state("m3t4", 4'b1000, 8'h04, 0, 0);
    fetch = 1; #1;
    chk("m3t4.irl", 32'(irl), 32'd1);
    clk1();
    chk_state("newm1", 4'b0001, 8'h01, 0, 0);
    chk("newm1.irl", 32'(irl), 32'd0);
    fetch = 0;

    // overflow after 8 M-cycles without fetch
    clks(31);
    chk_state("m8t4", 4'b1000, 8'h80, 0, 0);
    chk("m8t4.err", 32'(err), 32'd0);
    clk1();
    chk_state("wrap", 4'b0001, 8'h01, 0, 0);
    chk("wrap.err", 32'(err), 32'd1);
    clks(3);
    fetch = 1;
    clk1();
    fetch = 0;
    chk("sticky.err", 32'(err), 32'd1);
    chk("sticky.cnt", 32'(cnt), 32'h01);

    // HALT entry and interrupt exit
    clks(3);
    fetch = 1; halt = 1; #1;
    chk("hent.irl", 32'(irl), 32'd0);
    clk1();
    fetch = 0; halt = 0;
    chk_state("halt", 4'b0001, 8'h00, 1, 0);
    clk1();
    chk("halt.rot", 32'(step), 32'b0010);
    intp = 1; #1;
    chk("halt.t2irl", 32'(irl), 32'd0);
    clk1();
    chk_state("halt.t3", 4'b0100, 8'h00, 1, 0);
    clk1();
    chk("halt.t4irl", 32'(irl), 32'd1);
    clk1();
    intp = 0;
    chk_state("hexit", 4'b0001, 8'h01, 0, 0);

    // HALT with interrupt already pending
    clks(3);
    fetch = 1; halt = 1; intp = 1; #1;
    chk("hskip.irl", 32'(irl), 32'd1);
    clk1();
    fetch = 0; halt = 0; intp = 0;
    chk_state("hskip", 4'b0001, 8'h01, 0, 0);

    // STOP beats HALT, ignores interrupts
    clks(3);
    fetch = 1; halt = 1; stop = 1; #1;
    chk("sent.irl", 32'(irl), 32'd0);
    clk1();
    fetch = 0; halt = 0; stop = 0;
    chk_state("stop", 4'b0001, 8'h00, 0, 1);
    intp = 1;
    clks(4);
    chk_state("stop.int", 4'b0001, 8'h00, 0, 1);
    intp = 0;
    wake = 1;
    clk1();
    wake = 0;
    chk_state("wake", 4'b0001, 8'h01, 0, 0);
    clks(3);
    chk("wake.t4irl", 32'(irl), 32'd1);
    clk1();
    chk_state("wake.m1", 4'b0001, 8'h01, 0, 0);

    // bus stall at T3 of M2
    clks(6);
    chk_state("m2t3", 4'b0100, 8'h02, 0, 0);
    wt = 1;
    for (int i = 0; i < 5; i++) begin
      clk1();
      chk_state("wait", 4'b0100, 8'h02, 0, 0);
    end
    wt = 0;
    clk1();
    chk_state("resume", 4'b1000, 8'h02, 0, 0);
    wt = 1; fetch = 1; #1;
    chk("wait.irl", 32'(irl), 32'd0);
    clk1();
    chk_state("waitt4", 4'b1000, 8'h02, 0, 0);
    wt = 0; fetch = 0;
    clk1();
    chk_state("m3", 4'b0001, 8'h04, 0, 0);

    // reset at T3 of M5
    clks(10);
    chk_state("m5t3", 4'b0100, 8'h10, 0, 0);
    chk("m5t3.err", 32'(err), 32'd1);
    rst = 1;
    clk1();
    chk_state("rst2", 4'b0001, 8'h01, 0, 0);
    chk("rst2.err", 32'(err), 32'd0);
    chk("rst2.irl", 32'(irl), 32'd0);
    rst = 0;
    clks(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
- Timing generator for the CPU control unit. Produces the one-hot T-state step and the one-hot M-cycle count that every opcode-group decoder and microcode block consumes.
- Consumes the OR-ed fetch/done request and HALT/STOP requests that those decoders return.
- Sits between the clock/reset source and the X-group decoders. Also pulses the instruction-register latch at each instruction boundary.

Parameters:
- T_STATES, 4, T-states per M-cycle; width of o_Cycle_Step.
- MAX_MCYCLES, 8, maximum M-cycles per instruction; width of o_Cycle_Count.

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Fetch  input  1  OR of all decoder fetch outputs: current instruction ends at this M-cycle.
- i_Halt  input  1  HALT opcode executing; sampled with i_Fetch.
- i_Stop  input  1  STOP opcode executing; sampled with i_Fetch.
- i_Wait  input  1  bus stall (DMA/slow memory); freezes sequencing.
- i_Int_Pending  input  1  enabled interrupt pending; HALT wake source.
- i_Wake  input  1  joypad wake; STOP wake source.
- o_Cycle_Step  output  T_STATES  one-hot T-state, bit0 = T1.
- o_Cycle_Count  output  MAX_MCYCLES  one-hot M-cycle, bit0 = M1; all-zero while halted/stopped.
- o_IR_Latch  output  1  one-clock pulse: latch data bus into IR.
- o_Halted  output  1  in HALT state.
- o_Stopped  output  1  in STOP state.
- o_Cycle_Error  output  1  sticky: M-cycle overflow without fetch.

Behaviour:
- Reset (synchronous, i_Reset high at clock edge):
  - step = 0001, count = 0000_0001, state RUN.
  - o_IR_Latch = 0, o_Halted = 0, o_Stopped = 0, o_Cycle_Error = 0.
  - Reset mid-instruction or in HALT/STOP aborts immediately; no pending fetch survives.
- i_Wait high: all registers hold, outputs unchanged, o_IR_Latch forced 0. Priority is below reset and above everything else.
- Step: in RUN and HALT, rotates left one position per clock (T1→T2→T3→T4→T1). In STOP it is held at T1.
- M-cycle boundary: a clock edge where step = T4 and i_Wait = 0. i_Fetch, i_Halt and i_Stop are sampled only at a boundary and ignored at all other times.
- State RUN:
  - Boundary with i_Fetch=0: count shifts left 1.
    - If count bit MAX_MCYCLES-1 is already set, count wraps to 0000_0001 and o_Cycle_Error sets. It stays set until reset.
  - Boundary with i_Fetch=1, i_Halt=0, i_Stop=0: count = 0000_0001 and o_IR_Latch pulses high during that T4 clock (combinational on the boundary condition). Latency: the new opcode is visible to the decoders at the next T1.
  - Boundary with i_Fetch=1, i_Stop=1: go to STOP, count = 0, step = T1. i_Stop wins over i_Halt.
  - Boundary with i_Fetch=1, i_Halt=1, i_Stop=0:
    - If i_Int_Pending=1 in the same cycle, HALT is not entered: treat as a normal fetch.
    - Otherwise go to HALT, count = 0.
  - i_Halt or i_Stop without i_Fetch has no effect.
- State HALT:
  - o_Halted = 1, count = 0, step keeps rotating.
  - At a boundary with i_Int_Pending=1: go to RUN, count = 0000_0001, o_IR_Latch pulses.
- State STOP:
  - o_Stopped = 1, count = 0, step held at T1; i_Int_Pending is ignored.
  - When i_Wake=1 (any clock, i_Wait=0): go to RUN, step = T1, count = 0000_0001. o_IR_Latch pulses on the following T4.
- Invariants:
  - Step is always exactly one-hot.
  - Count is exactly one-hot in RUN and zero in HALT/STOP.
  - The bench asserts both every clock.

Optional Feature:
- CPU_CYCLE_SEQ_PERF_COUNTER_EN.
- Defined:
  - Adds output o_MCycle_Total (32-bit), cleared by reset.
  - Increments by 1 at every boundary in RUN, and holds in HALT, STOP and during i_Wait.
  - Wraps from 0xFFFF_FFFF to 0 silently.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Release reset, i_Fetch=0 for 8 clocks → step 0001,0010,0100,1000,0001…; count 0000_0001 then 0000_0010 at the 2nd M1.
- i_Fetch=1 at T4 of M3 → o_IR_Latch high for exactly that clock; next T1 has count 0000_0001. No latch pulse when i_Fetch is raised at T2.
- i_Fetch=0 for 8 full M-cycles → count wraps 1000_0000→0000_0001 and o_Cycle_Error=1; it stays 1 after later fetches and clears only on i_Reset.
- HALT path:
  - i_Fetch=1 with i_Halt=1 at T4 → o_Halted=1, count=0, step keeps rotating.
  - Raise i_Int_Pending at T2 → exit only at the next T4, with a latch pulse and count 0000_0001.
  - Repeat with i_Int_Pending=1 at entry → HALT never entered.
- STOP path:
  - i_Fetch=1 with i_Halt=1 and i_Stop=1 → STOP (not HALT), step frozen at 0001.
  - i_Int_Pending ignored; i_Wake=1 → RUN at T1, count 0000_0001.
- Stalls and reset:
  - i_Wait held 5 clocks at T3 of M2 → all outputs frozen, then resume at T4 of M2.
  - i_Reset asserted during T3 of M5 → next clock step 0001, count 0000_0001, all flags 0.
